// File: rtl/l1_traffic_generator_if.sv
// rtl/l1_traffic_generator_if.sv - L1 data-cache request/response bus between initiator and cache
interface l1_traffic_generator_if #(
    parameter int n = 32
);
    logic         L1_busy;
    logic [n-1:0] dmem_rdata;
    logic         load_control;
    logic         store_control;
    logic [n-1:0] dmem_wdata;
    logic [14:0]  address;

    // Initiator side: drives requests, observes stall and load data.
    modport master (
        input  L1_busy,
        input  dmem_rdata,
        output load_control,
        output store_control,
        output dmem_wdata,
        output address
    );

    // Cache side: observes requests, answers with stall and load data.
    modport slave (
        output L1_busy,
        output dmem_rdata,
        input  load_control,
        input  store_control,
        input  dmem_wdata,
        input  address
    );
endinterface

// File: rtl/l1_traffic_generator.sv
// rtl/l1_traffic_generator.sv - self-checking store-then-load initiator for the L1 data-cache port
module l1_traffic_generator #(
    parameter int          n      = 32,
    parameter logic [14:0] BASE   = 15'h0000,
    parameter int          COUNT  = 64,
    parameter logic [14:0] STRIDE = 15'd1,
    parameter logic [n-1:0] SEED  = 32'hA5A5_0000,
    parameter int          GAP    = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    l1_traffic_generator_if.master       bus,
    output logic                         program_done,
    output logic                         error,
    output logic [15:0]                  err_count,
    output logic [14:0]                  first_err_address
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_LOAD,
        ST_WAIT_GAP,
        ST_DONE
    } state_t;

    localparam logic [14:0]  IDX_LAST = 15'(COUNT - 1);
    localparam logic [31:0]  GAP_LAST = GAP - 1;
    localparam bit           HAS_GAP  = (GAP > 0);
    localparam logic [n-1:0] DATA_ONE = {{(n-1){1'b0}}, 1'b1};

    state_t       state, state_n;
    logic         loading, loading_n;
    logic [14:0]  idx, idx_n;
    logic [31:0]  gap_cnt, gap_n;
    logic [14:0]  addr_q, addr_n;
    logic [n-1:0] data_q, data_n;
    logic         store_q, store_n;
    logic         load_q, load_n;
    logic         done_q, done_n;
    logic         err_q, err_n;
    logic [15:0]  err_cnt_q, err_cnt_n;
    logic [14:0]  first_q, first_n;
    logic         advance;

    // State and every output are registers; async reset returns all of them to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            loading   <= 1'b0;
            idx       <= '0;
            gap_cnt   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            store_q   <= 1'b0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            first_q   <= '0;
        end else begin
            state     <= state_n;
            loading   <= loading_n;
            idx       <= idx_n;
            gap_cnt   <= gap_n;
            addr_q    <= addr_n;
            data_q    <= data_n;
            store_q   <= store_n;
            load_q    <= load_n;
            done_q    <= done_n;
            err_q     <= err_n;
            err_cnt_q <= err_cnt_n;
            first_q   <= first_n;
        end
    end

    // Next-state: accept on !L1_busy, check load data, optionally idle GAP cycles, then step the index.
    always_comb begin
        state_n   = state;
        loading_n = loading;
        idx_n     = idx;
        gap_n     = gap_cnt;
        addr_n    = addr_q;
        data_n    = data_q;
        store_n   = store_q;
        load_n    = load_q;
        done_n    = done_q;
        err_n     = err_q;
        err_cnt_n = err_cnt_q;
        first_n   = first_q;
        advance   = 1'b0;

        case (state)
            ST_IDLE: begin
                state_n   = ST_STORE;
                loading_n = 1'b0;
                idx_n     = '0;
                addr_n    = BASE;
                data_n    = SEED;
                store_n   = 1'b1;
                load_n    = 1'b0;
            end
            ST_STORE, ST_LOAD: begin
                if (!bus.L1_busy) begin
                    store_n = 1'b0;
                    load_n  = 1'b0;
                    if (state == ST_LOAD && bus.dmem_rdata != data_q) begin
                        err_n = 1'b1;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_n = err_cnt_q + 16'd1;
                        end
                        if (err_cnt_q == 16'd0) begin
                            first_n = addr_q;
                        end
                    end
                    if (HAS_GAP) begin
                        state_n = ST_WAIT_GAP;
                        gap_n   = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_WAIT_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    gap_n = gap_cnt + 32'd1;
                end
            end
            ST_DONE: begin
                done_n = 1'b1;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Present the following access, switch from stores to loads, or finish.
        if (advance) begin
            if (idx != IDX_LAST) begin
                idx_n  = idx + 15'd1;
                addr_n = addr_q + STRIDE;
                data_n = data_q + DATA_ONE;
                if (loading) begin
                    load_n  = 1'b1;
                    state_n = ST_LOAD;
                end else begin
                    store_n = 1'b1;
                    state_n = ST_STORE;
                end
            end else if (!loading) begin
                idx_n     = '0;
                addr_n    = BASE;
                data_n    = SEED;
                loading_n = 1'b1;
                load_n    = 1'b1;
                state_n   = ST_LOAD;
            end else begin
                state_n = ST_DONE;
            end
        end
    end

    assign bus.store_control  = store_q;
    assign bus.load_control   = load_q;
    assign bus.address        = addr_q;
    assign bus.dmem_wdata     = data_q;
    assign program_done       = done_q;
    assign error              = err_q;
    assign err_count          = err_cnt_q;
    assign first_err_address  = first_q;

endmodule

// File: tb/tb_l1_traffic_generator.sv
// tb/tb_l1_traffic_generator.sv - self-checking bench for l1_traffic_generator
module tb_l1_traffic_generator;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic [2:0]  rst = 3'b111;
    logic        busy = 1'b0;
    logic [31:0] rdata = '0;
    int          cur_sel = 0;

    always #5 clk = ~clk;

    l1_traffic_generator_if #(.n(N)) bus_a ();
    l1_traffic_generator_if #(.n(N)) bus_b ();
    l1_traffic_generator_if #(.n(N)) bus_c ();

    assign bus_a.L1_busy = busy;
    assign bus_a.dmem_rdata = rdata;
    assign bus_b.L1_busy = busy;
    assign bus_b.dmem_rdata = rdata;
    assign bus_c.L1_busy = busy;
    assign bus_c.dmem_rdata = rdata;

    logic        done_a, done_b, done_c;
    logic        err_a, err_b, err_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;
    logic [14:0] fea_a, fea_b, fea_c;

    l1_traffic_generator #(.n(N), .BASE(15'h0000), .COUNT(4), .STRIDE(15'd1),
                           .SEED(32'hA5A5_0000), .GAP(0)) dut_a (
        .clk(clk), .reset(rst[0]), .bus(bus_a), .program_done(done_a),
        .error(err_a), .err_count(cnt_a), .first_err_address(fea_a));

    l1_traffic_generator #(.n(N), .BASE(15'h7FFE), .COUNT(4), .STRIDE(15'd1),
                           .SEED(32'hA5A5_0000), .GAP(2)) dut_b (
        .clk(clk), .reset(rst[1]), .bus(bus_b), .program_done(done_b),
        .error(err_b), .err_count(cnt_b), .first_err_address(fea_b));

    l1_traffic_generator #(.n(N), .BASE(15'h0005), .COUNT(40), .STRIDE(15'h0400),
                           .SEED(32'h1234_5678), .GAP(1)) dut_c (
        .clk(clk), .reset(rst[2]), .bus(bus_c), .program_done(done_c),
        .error(err_c), .err_count(cnt_c), .first_err_address(fea_c));

    logic        o_store, o_load, o_done, o_err;
    logic [14:0] o_addr, o_first;
    logic [31:0] o_wdata;
    logic [15:0] o_cnt;

    always_comb begin
        o_store = bus_a.store_control;
        o_load  = bus_a.load_control;
        o_addr  = bus_a.address;
        o_wdata = bus_a.dmem_wdata;
        o_done  = done_a;
        o_err   = err_a;
        o_cnt   = cnt_a;
        o_first = fea_a;
        if (cur_sel == 1) begin
            o_store = bus_b.store_control;
            o_load  = bus_b.load_control;
            o_addr  = bus_b.address;
            o_wdata = bus_b.dmem_wdata;
            o_done  = done_b;
            o_err   = err_b;
            o_cnt   = cnt_b;
            o_first = fea_b;
        end else if (cur_sel == 2) begin
            o_store = bus_c.store_control;
            o_load  = bus_c.load_control;
            o_addr  = bus_c.address;
            o_wdata = bus_c.dmem_wdata;
            o_done  = done_c;
            o_err   = err_c;
            o_cnt   = cnt_c;
            o_first = fea_c;
        end
    end

    int          cfg_base   [3] = '{0, 32766, 5};
    int          cfg_count  [3] = '{4, 4, 40};
    int          cfg_stride [3] = '{1, 1, 1024};
    int          cfg_gap    [3] = '{0, 2, 1};
    logic [31:0] cfg_seed   [3] = '{32'hA5A5_0000, 32'hA5A5_0000, 32'h1234_5678};

    logic [31:0] mem [0:32767];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {o_store, o_load, o_addr, o_wdata, o_done, o_err, o_cnt, o_first}, 128'd0);
    endtask

    typedef struct {
        int sel;
        int busy_pct;
        int stall_idx;
        int stall_len;
        int corrupt;
        int exp_done;
        int exp_errs;
        int exp_first;
    } case_t;

    task automatic run_case(input case_t c);
        int          count, gap, total;
        int          acc_addr [80];
        logic [31:0] acc_data [80];
        bit          acc_ld   [80];
        int          k, kk, countdown, e, stall_used, m_errs, m_first, done_edge, post_done;
        bit          req, exp_done, finished;

        count = cfg_count[c.sel];
        gap   = cfg_gap[c.sel];
        total = 2 * count;
        for (int i = 0; i < count; i++) begin
            acc_addr[i]         = (cfg_base[c.sel] + i * cfg_stride[c.sel]) % 32768;
            acc_data[i]         = cfg_seed[c.sel] + 32'(i);
            acc_ld[i]           = 1'b0;
            acc_addr[count + i] = acc_addr[i];
            acc_data[count + i] = acc_data[i];
            acc_ld[count + i]   = 1'b1;
        end

        cur_sel = c.sel;
        rst     = 3'b111;
        busy    = 1'b0;
        rdata   = '0;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        rst[c.sel] = 1'b0;

        k = 0; countdown = 1; e = 0; stall_used = 0;
        m_errs = 0; m_first = 0; done_edge = -1; post_done = 0; finished = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            req      = (k < total) && (countdown == 0);
            exp_done = (k == total) && (countdown == 0);
            kk       = (k < total) ? k : 0;
            check("store_control", o_store, req && !acc_ld[kk]);
            check("load_control", o_load, req && acc_ld[kk]);
            if (req) check("address", o_addr, acc_addr[kk]);
            if (req && !acc_ld[kk]) check("dmem_wdata", o_wdata, acc_data[kk]);
            check("program_done", o_done, exp_done);
            if (exp_done) begin
                if (done_edge < 0) done_edge = e;
                post_done++;
                if (post_done > 3) begin
                    finished = 1'b1;
                    break;
                end
            end

            if (req && !acc_ld[kk] && kk == c.stall_idx && stall_used < c.stall_len) begin
                busy = 1'b1;
                stall_used++;
            end else begin
                busy = ($urandom_range(99) < c.busy_pct);
            end
            rdata = '0;
            if (req && acc_ld[kk])
                rdata = mem[acc_addr[kk]] ^ ((acc_addr[kk] == c.corrupt) ? 32'd1 : 32'd0);

            @(posedge clk);
            e++;
            if (req && !busy) begin
                if (!acc_ld[kk]) begin
                    mem[acc_addr[kk]] = acc_data[kk];
                end else if (rdata != acc_data[kk]) begin
                    if (m_errs == 0) m_first = acc_addr[kk];
                    m_errs++;
                end
                k++;
                countdown = (k == total) ? gap + 1 : gap;
            end else if (countdown > 0) begin
                countdown--;
            end
            @(negedge clk);
        end

        if (!finished) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: program_done not reached, got k=%0d expected k=%0d", k, total);
        end
        check("err_count", o_cnt, m_errs);
        check("error", o_err, m_errs > 0);
        check("first_err_address", o_first, (m_errs > 0) ? m_first : 0);
        if (c.exp_done >= 0) check("done_edge", done_edge, c.exp_done);
        if (c.exp_errs >= 0) begin
            check("table_err_count", o_cnt, c.exp_errs);
            check("table_first_err", o_first, (c.exp_errs > 0) ? c.exp_first : 0);
        end

        #2;
        rst[c.sel] = 1'b1;
        #1;
        check_zero("reset_in_done");
        busy = 1'b0;
    endtask

    case_t cases [8];

    initial begin
        bit seen_load;

        cases[0] = '{sel: 0, busy_pct: 0,  stall_idx: -1, stall_len: 0, corrupt: -1,    exp_done: 10,  exp_errs: 0, exp_first: 0};
        cases[1] = '{sel: 0, busy_pct: 0,  stall_idx: 1,  stall_len: 5, corrupt: -1,    exp_done: 15,  exp_errs: 0, exp_first: 0};
        cases[2] = '{sel: 0, busy_pct: 0,  stall_idx: -1, stall_len: 0, corrupt: 2,     exp_done: 10,  exp_errs: 1, exp_first: 2};
        cases[3] = '{sel: 1, busy_pct: 0,  stall_idx: -1, stall_len: 0, corrupt: -1,    exp_done: 26,  exp_errs: 0, exp_first: 0};
        cases[4] = '{sel: 0, busy_pct: 40, stall_idx: -1, stall_len: 0, corrupt: -1,    exp_done: -1,  exp_errs: 0, exp_first: 0};
        cases[5] = '{sel: 2, busy_pct: 30, stall_idx: -1, stall_len: 0, corrupt: -1,    exp_done: -1,  exp_errs: 8, exp_first: 5};
        cases[6] = '{sel: 2, busy_pct: 0,  stall_idx: -1, stall_len: 0, corrupt: -1,    exp_done: 162, exp_errs: 8, exp_first: 5};
        cases[7] = '{sel: 1, busy_pct: 50, stall_idx: -1, stall_len: 0, corrupt: 32767, exp_done: -1,  exp_errs: 1, exp_first: 32767};

        for (int i = 0; i < 8; i++) begin
            run_case(cases[i]);
        end

        // Reset asserted mid-LOAD, then the sequence restarts with a store to BASE.
        cur_sel = 0;
        rst     = 3'b111;
        busy    = 1'b0;
        rdata   = '0;
        @(negedge clk);
        rst[0]    = 1'b0;
        seen_load = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (o_load) begin
                seen_load = 1'b1;
                break;
            end
        end
        check("reached_load", seen_load, 1'b1);
        #2;
        rst[0] = 1'b1;
        #1;
        check_zero("reset_mid_load");
        @(negedge clk);
        rst[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("restart_store", {o_store, o_load, o_addr, o_wdata}, {1'b1, 1'b0, 15'h0000, 32'hA5A5_0000});
        @(posedge clk);
        @(negedge clk);
        check("restart_next", {o_store, o_load, o_addr, o_wdata}, {1'b1, 1'b0, 15'h0001, 32'hA5A5_0001});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
